// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - instruction fetch controller with ready/valid decode handoff, redirect and halt
// Optional fetch-bound fault checking is enabled by defining FETCH_BOUND_EN.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] ROM_LAST = 32'h00000018
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fault
);

`ifdef FETCH_BOUND_EN
  localparam logic BOUND_EN = 1'b1;
`else
  localparam logic BOUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_FETCH, S_STALL, S_HALTED, S_FAULT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fpc, w_fpc_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_fault, w_fault_nxt;

  logic        w_load;
  logic [31:0] w_target;
  logic        w_fpc_oob;
  logic        w_tgt_oob;

  assign w_load    = !r_valid | inst_ready;
  assign w_target  = redirect_pc & 32'hFFFF_FFFC;
  assign w_fpc_oob = BOUND_EN && (r_fpc > ROM_LAST);
  assign w_tgt_oob = BOUND_EN && (w_target > ROM_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_inst_nxt  = r_inst;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_fault_nxt = r_fault;
    case (r_state)
      S_FETCH, S_STALL: begin
        if (redirect_valid) begin
          w_fpc_nxt   = w_target;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_FETCH;
        end else if (w_load) begin
          // A pending instruction is always handed off before halt takes effect
          if (halt) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = S_HALTED;
          end else if (w_fpc_oob) begin
            w_valid_nxt = 1'b0;
            w_fault_nxt = 1'b1;
            w_state_nxt = S_FAULT;
          end else begin
            w_inst_nxt  = rom_data;
            w_pc_nxt    = r_fpc;
            w_valid_nxt = 1'b1;
            w_fpc_nxt   = r_fpc + 32'd4;
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_state_nxt = S_STALL;
        end
      end
      S_HALTED: begin
        w_valid_nxt = 1'b0;
        if (redirect_valid && !halt) begin
          w_fpc_nxt   = w_target;
          w_state_nxt = S_FETCH;
        end
      end
      S_FAULT: begin
        w_valid_nxt = 1'b0;
        if (redirect_valid) begin
          w_fpc_nxt = w_target;
          if (!w_tgt_oob) begin
            w_fault_nxt = 1'b0;
            w_state_nxt = S_FETCH;
          end
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_fpc   <= RESET_PC;
      r_inst  <= 32'h0;
      r_pc    <= 32'h0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
      r_inst  <= w_inst_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  assign rom_addr   = r_fpc;
  assign inst_out   = r_inst;
  assign pc_out     = r_pc;
  assign inst_valid = r_valid;
  assign fault      = BOUND_EN & r_fault;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - self-checking bench for ifetch_ctrl with a ROM model and expected-instruction queue
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fault;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic found;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_model(input logic [31:0] a);
    case (a)
      32'h00: return 32'h00400093;
      32'h04: return 32'h00800113;
      32'h08: return 32'h002081B3;
      32'h0C: return 32'h00100023;
      32'h10: return 32'h00208233;
      32'h14: return 32'h0041A023;
      32'h18: return 32'h40210463;
      default: return 32'hBAD00000 ^ a;
    endcase
  endfunction

  always_comb rom_data = rom_model(rom_addr);

  ifetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt), .fault(fault)
  );

  task automatic apply_reset;
    rst_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 00000000", inst_out); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", pc_out); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 00000000", rom_addr); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'h00400093) begin
      errors++; $display("FAIL first_fetch: got v=%b pc=%h inst=%h expected v=1 pc=00000000 inst=00400093", inst_valid, pc_out, inst_out);
    end
  endtask

  task automatic test_stream;
    apply_reset();
    exp_q.delete();
    for (int a = 0; a <= 24; a += 4) exp_q.push_back({32'(a), rom_model(32'(a))});
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (pc_out !== e.pc || inst_out !== e.inst) begin
          errors++; $display("FAIL stream: got pc=%h inst=%h expected pc=%h inst=%h", pc_out, inst_out, e.pc, e.inst);
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_timeout: got %0d pending expected 0", exp_q.size()); end
    @(negedge clk);
`ifdef FETCH_BOUND_EN
    checks++; if (fault !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL bound_fault: got f=%b v=%b expected f=1 v=0", fault, inst_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h1C;
    @(negedge clk);
    checks++; if (fault !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL bound_sticky: got f=%b v=%b expected f=1 v=0", fault, inst_valid); end
    redirect_pc = 32'h0;
    @(negedge clk);
    checks++; if (fault !== 1'b0 || rom_addr !== 32'h0) begin errors++; $display("FAIL bound_clear: got f=%b addr=%h expected f=0 addr=00000000", fault, rom_addr); end
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'h00400093) begin
      errors++; $display("FAIL bound_restart: got v=%b pc=%h inst=%h expected v=1 pc=00000000 inst=00400093", inst_valid, pc_out, inst_out);
    end
`else
    checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h1C || inst_out !== rom_model(32'h1C) || fault !== 1'b0) begin
      errors++; $display("FAIL past_rom_last: got v=%b pc=%h inst=%h f=%b expected v=1 pc=0000001c inst=%h f=0",
                         inst_valid, pc_out, inst_out, fault, rom_model(32'h1C));
    end
`endif
  endtask

  task automatic test_stall;
    apply_reset();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin @(negedge clk); if (inst_valid && pc_out == 32'h4) found = 1'b1; end
    checks++; if (!found) begin errors++; $display("FAIL stall_reach_pc4: got none expected pc 00000004"); end
    inst_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || pc_out !== 32'h4 || inst_out !== 32'h00800113 || rom_addr !== 32'h8) begin
        errors++; $display("FAIL stall_hold: got v=%b pc=%h inst=%h addr=%h expected v=1 pc=00000004 inst=00800113 addr=00000008",
                           inst_valid, pc_out, inst_out, rom_addr);
      end
    end
    inst_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (pc_out !== 32'h8 || inst_out !== 32'h002081B3) begin
      errors++; $display("FAIL stall_release: got pc=%h inst=%h expected pc=00000008 inst=002081b3", pc_out, inst_out);
    end
  endtask

  task automatic test_redirect;
    apply_reset();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin @(negedge clk); if (inst_valid && pc_out == 32'h4) found = 1'b1; end
    checks++; if (!found) begin errors++; $display("FAIL redir_reach_pc4: got none expected pc 00000004"); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000000E;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0 || rom_addr !== 32'hC) begin errors++; $display("FAIL redir_flush: got v=%b addr=%h expected v=0 addr=0000000c", inst_valid, rom_addr); end
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'hC || inst_out !== 32'h00100023) begin
      errors++; $display("FAIL redir_target: got v=%b pc=%h inst=%h expected v=1 pc=0000000c inst=00100023", inst_valid, pc_out, inst_out);
    end
  endtask

  task automatic test_halt;
    apply_reset();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin @(negedge clk); if (inst_valid && pc_out == 32'h8) found = 1'b1; end
    checks++; if (!found) begin errors++; $display("FAIL halt_reach_pc8: got none expected pc 00000008"); end
    inst_ready = 1'b0; halt = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h8) begin errors++; $display("FAIL halt_hold: got v=%b pc=%h expected v=1 pc=00000008", inst_valid, pc_out); end
    end
    inst_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (inst_valid !== 1'b0 || rom_addr !== 32'hC) begin errors++; $display("FAIL halt_idle: got v=%b addr=%h expected v=0 addr=0000000c", inst_valid, rom_addr); end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0 || rom_addr !== 32'hC) begin errors++; $display("FAIL halt_redir_blocked: got v=%b addr=%h expected v=0 addr=0000000c", inst_valid, rom_addr); end
    halt = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0 || rom_addr !== 32'h0) begin errors++; $display("FAIL halt_redir_exit: got v=%b addr=%h expected v=0 addr=00000000", inst_valid, rom_addr); end
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'h00400093) begin
      errors++; $display("FAIL halt_restart: got v=%b pc=%h inst=%h expected v=1 pc=00000000 inst=00400093", inst_valid, pc_out, inst_out);
    end
  endtask

  task automatic test_async_reset;
    apply_reset();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin @(negedge clk); if (inst_valid && pc_out == 32'h4) found = 1'b1; end
    checks++; if (!found) begin errors++; $display("FAIL areset_reach_pc4: got none expected pc 00000004"); end
    inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'h0 || rom_addr !== 32'h0) begin
      errors++; $display("FAIL areset_clear: got v=%b inst=%h pc=%h addr=%h expected all zero", inst_valid, inst_out, pc_out, rom_addr);
    end
    @(negedge clk);
    rst_n = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h0) begin errors++; $display("FAIL areset_restart: got v=%b pc=%h expected v=1 pc=00000000", inst_valid, pc_out); end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    exp_q.delete();
    for (int a = 0; a <= 16; a += 4) exp_q.push_back({32'(a), rom_model(32'(a))});
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      inst_ready = 1'($urandom_range(0, 1));
      if (inst_valid && inst_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (pc_out !== e.pc || inst_out !== e.inst) begin
          errors++; $display("FAIL b2b: got pc=%h inst=%h expected pc=%h inst=%h", pc_out, inst_out, e.pc, e.inst);
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_timeout: got %0d pending expected 0", exp_q.size()); end
    inst_ready = 1'b1;
  endtask

  task automatic test_wrap;
    apply_reset();
    @(negedge clk);
`ifdef FETCH_BOUND_EN
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (fault !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL redir_oob_fault: got f=%b v=%b expected f=1 v=0", fault, inst_valid); end
`else
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF;
    @(negedge clk);
    checks++; if (rom_addr !== 32'hFFFFFFFC || inst_valid !== 1'b0) begin errors++; $display("FAIL wrap_redir: got addr=%h v=%b expected addr=fffffffc v=0", rom_addr, inst_valid); end
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pc_out !== 32'hFFFFFFFC || inst_out !== rom_model(32'hFFFFFFFC) || rom_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_fpc: got pc=%h inst=%h addr=%h expected pc=fffffffc inst=%h addr=00000000",
                         pc_out, inst_out, rom_addr, rom_model(32'hFFFFFFFC));
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_async_reset();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
